// File: rtl/acs_scheduler_if.sv
// Bundles the scheduler's symbol, ACS and survivor ports.
// master = scheduler side, slave = surrounding datapath.
interface acs_scheduler_if #(
  parameter int unsigned PM_W = 7
);
  logic            sym_valid;
  logic [1:0]      sym_data;
  logic            frame_start;
  logic            sym_ready;

  logic            acs_input_sig;
  logic [1:0]      acs_self_state;
  logic [1:0]      acs_data_recv;
  logic [1:0]      acs_addr_in_1;
  logic [1:0]      acs_addr_in_2;
  logic [PM_W-1:0] acs_pmin1;
  logic [PM_W-1:0] acs_pmin2;
  logic [PM_W-1:0] acs_pmout;
  logic [1:0]      acs_addr_out;
  logic            acs_dec;

  logic            surv_valid;
  logic [3:0]      surv_data;
  logic            surv_ready;
  logic [1:0]      best_state;
  logic            norm_evt;

  modport master (
    input  sym_valid, sym_data, frame_start,
           acs_pmout, acs_addr_out, acs_dec, surv_ready,
    output sym_ready, acs_input_sig, acs_self_state, acs_data_recv,
           acs_addr_in_1, acs_addr_in_2, acs_pmin1, acs_pmin2,
           surv_valid, surv_data, best_state, norm_evt
  );

  modport slave (
    output sym_valid, sym_data, frame_start,
           acs_pmout, acs_addr_out, acs_dec, surv_ready,
    input  sym_ready, acs_input_sig, acs_self_state, acs_data_recv,
           acs_addr_in_1, acs_addr_in_2, acs_pmin1, acs_pmin2,
           surv_valid, surv_data, best_state, norm_evt
  );
endinterface

// File: rtl/acs_scheduler.sv
// Time-multiplexes one ACS unit over the 4 states of the K=3 trellis,
// keeping ping-pong path-metric banks with MSB normalisation at commit.
module acs_scheduler #(
  parameter int unsigned PM_W    = 7,
  parameter int unsigned ACS_LAT = 0,
  parameter int unsigned INIT_PM = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  acs_scheduler_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_COMMIT,
    S_OUT
  } state_t;

  localparam logic [PM_W-1:0] INIT_V  = PM_W'(INIT_PM);
  localparam logic [PM_W-1:0] MSB_CLR = {1'b0, {(PM_W-1){1'b1}}};

  state_t          state, state_nxt;
  logic [1:0]      idx;
  logic [1:0]      drain_cnt;
  logic [1:0]      sym_q;
  logic [PM_W-1:0] cur_pm [4];
  logic [PM_W-1:0] nxt_pm [4];
  logic [PM_W-1:0] cmt_pm [4];
  logic [3:0]      surv_acc;
  logic [3:0]      surv_q;
  logic [1:0]      best_q;
  logic [1:0]      best_c;
  logic            all_msb;
  logic            accept;
  logic            issuing;
  logic            drain_done;
  logic            cap_valid;
  logic [1:0]      cap_idx;

  assign accept     = (state == S_IDLE) && bus.sym_valid;
  assign issuing    = (state == S_ISSUE);
  assign drain_done = (32'(drain_cnt) + 32'd1) == ACS_LAT;

  // Results return ACS_LAT cycles after issue; track which state each belongs to.
  generate
    if (ACS_LAT == 0) begin : g_nolat
      assign cap_valid = issuing;
      assign cap_idx   = idx;
    end else begin : g_lat
      logic [ACS_LAT-1:0] pipe_v;
      logic [1:0]         pipe_idx [ACS_LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_v <= '0;
          for (int unsigned i = 0; i < ACS_LAT; i++) pipe_idx[i] <= '0;
        end else begin
          pipe_v[0]   <= issuing;
          pipe_idx[0] <= idx;
          for (int unsigned i = 1; i < ACS_LAT; i++) begin
            pipe_v[i]   <= pipe_v[i-1];
            pipe_idx[i] <= pipe_idx[i-1];
          end
        end
      end

      assign cap_valid = pipe_v[ACS_LAT-1];
      assign cap_idx   = pipe_idx[ACS_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (accept) state_nxt = S_ISSUE;
      S_ISSUE:  if (idx == 2'd3) state_nxt = (ACS_LAT == 0) ? S_COMMIT : S_DRAIN;
      S_DRAIN:  if (drain_done) state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_OUT;
      S_OUT:    if (bus.surv_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Normalised view of the next bank plus its argmin, consumed only in COMMIT.
  always_comb begin
    all_msb = 1'b1;
    for (int unsigned i = 0; i < 4; i++) all_msb = all_msb & nxt_pm[i][PM_W-1];
    for (int unsigned i = 0; i < 4; i++) cmt_pm[i] = all_msb ? (nxt_pm[i] & MSB_CLR) : nxt_pm[i];
    best_c = 2'd0;
    for (int unsigned i = 1; i < 4; i++) begin
      if (cmt_pm[i] < cmt_pm[best_c]) best_c = 2'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      drain_cnt <= '0;
      sym_q     <= '0;
      surv_acc  <= '0;
      surv_q    <= '0;
      best_q    <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        cur_pm[i] <= (i == 0) ? '0 : INIT_V;
        nxt_pm[i] <= '0;
      end
    end else begin
      if (accept) begin
        sym_q     <= bus.sym_data;
        idx       <= '0;
        drain_cnt <= '0;
        if (bus.frame_start) begin
          for (int unsigned i = 0; i < 4; i++) cur_pm[i] <= (i == 0) ? '0 : INIT_V;
        end
      end
      if (issuing) idx <= idx + 2'd1;
      if (state == S_DRAIN) drain_cnt <= drain_cnt + 2'd1;
      if (cap_valid) begin
        nxt_pm[cap_idx]   <= bus.acs_pmout;
        surv_acc[cap_idx] <= bus.acs_dec;
      end
      if (state == S_COMMIT) begin
        for (int unsigned i = 0; i < 4; i++) cur_pm[i] <= cmt_pm[i];
        surv_q <= surv_acc;
        best_q <= best_c;
      end
    end
  end

  always_comb begin
    bus.acs_input_sig  = 1'b0;
    bus.acs_self_state = '0;
    bus.acs_data_recv  = '0;
    bus.acs_addr_in_1  = '0;
    bus.acs_addr_in_2  = '0;
    bus.acs_pmin1      = '0;
    bus.acs_pmin2      = '0;
    if (issuing) begin
      bus.acs_input_sig  = 1'b1;
      bus.acs_self_state = idx;
      bus.acs_data_recv  = sym_q;
      bus.acs_addr_in_1  = {idx[0], 1'b0};
      bus.acs_addr_in_2  = {idx[0], 1'b1};
      bus.acs_pmin1      = cur_pm[{idx[0], 1'b0}];
      bus.acs_pmin2      = cur_pm[{idx[0], 1'b1}];
    end
  end

  assign bus.sym_ready  = (state == S_IDLE);
  assign bus.surv_valid = (state == S_OUT);
  assign bus.surv_data  = surv_q;
  assign bus.best_state = best_q;
  assign bus.norm_evt   = (state == S_COMMIT) && all_msb;

endmodule

// File: tb/tb_acs_scheduler.sv
// Bench for acs_scheduler: pipelined ACS stub, forced-metric vector table,
// reset/back-pressure sequences and randomized symbols against a trellis model.
module tb_acs_scheduler;
  localparam int unsigned PM_W = 7;
  localparam int unsigned LAT  = 2;
  localparam int unsigned INIT = 32;
  localparam int          HALF = 1 << (PM_W - 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  acs_scheduler_if #(.PM_W(PM_W)) bus ();

  acs_scheduler #(.PM_W(PM_W), .ACS_LAT(LAT), .INIT_PM(INIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ACS stub: mode 0 = plain min, 1 = min with branch metrics, 2 = forced results
  int                    acs_mode = 0;
  logic [3:0][PM_W-1:0]  force_pm = '0;
  logic [3:0]            force_dec = '0;
  logic [PM_W+2:0]       s_res;
  logic [PM_W+2:0]       p1 = '0;
  logic [PM_W+2:0]       p2 = '0;

  function automatic logic [PM_W:0] acs_eval(input int mode, input int a, input int b,
                                             input logic [1:0] sym, input logic [1:0] st);
    logic [1:0] o1, o2;
    int c1, c2;
    o1 = {st[1] ^ st[0], st[1]};
    o2 = ~o1;
    c1 = a;
    c2 = b;
    if (mode == 1) begin
      c1 += $countones(sym ^ o1);
      c2 += $countones(sym ^ o2);
    end
    if (c2 < c1) return {1'b1, PM_W'(c2)};
    return {1'b0, PM_W'(c1)};
  endfunction

  always_comb begin
    logic [PM_W:0] r;
    if (acs_mode == 2) r = {force_dec[bus.acs_self_state], force_pm[bus.acs_self_state]};
    else r = acs_eval(acs_mode, int'(bus.acs_pmin1), int'(bus.acs_pmin2),
                      bus.acs_data_recv, bus.acs_self_state);
    s_res = {r[PM_W] ? bus.acs_addr_in_2 : bus.acs_addr_in_1, r};
  end

  always @(posedge clk) begin
    p1 <= s_res;
    p2 <= p1;
  end

  assign bus.acs_pmout    = p2[PM_W-1:0];
  assign bus.acs_dec      = p2[PM_W];
  assign bus.acs_addr_out = p2[PM_W+2:PM_W+1];

  // Trellis reference: new PM[s] = ACS over PM[2*(s%2)], PM[2*(s%2)+1]
  int         m_pm [4];
  int         m_nx [4];
  logic [3:0] e_surv;
  logic [1:0] e_best;
  logic       e_norm;

  task automatic model_init();
    m_pm[0] = 0;
    for (int s = 1; s < 4; s++) m_pm[s] = INIT;
  endtask

  task automatic ref_step(input logic [1:0] sym, input int mode);
    logic [PM_W:0] r;
    e_surv = '0;
    e_norm = 1'b1;
    for (int s = 0; s < 4; s++) begin
      r = acs_eval(mode, m_pm[(s % 2) * 2], m_pm[(s % 2) * 2 + 1], sym, 2'(s));
      m_nx[s]   = int'(r[PM_W-1:0]);
      e_surv[s] = r[PM_W];
      if (m_nx[s] < HALF) e_norm = 1'b0;
    end
    if (e_norm) for (int s = 0; s < 4; s++) m_nx[s] -= HALF;
    e_best = 2'd0;
    for (int s = 1; s < 4; s++) if (m_nx[s] < m_nx[e_best]) e_best = 2'(s);
  endtask

  task automatic run_symbol(input logic [1:0] sym, input logic fs, input logic [3:0] xs,
                            input logic [1:0] xb, input logic xn, input int hold);
    int n, issued, norm_cnt;
    n = 0;
    while (!bus.sym_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", bus.sym_ready, 1);
    bus.surv_ready  = (hold == 0);
    bus.sym_valid   = 1'b1;
    bus.sym_data    = sym;
    bus.frame_start = fs;
    @(posedge clk);
    @(negedge clk);
    // keep valid high with changed data: a busy scheduler must ignore it
    bus.sym_data    = ~sym;
    bus.frame_start = 1'b1;
    n = 1;
    issued = 0;
    norm_cnt = 0;
    while (!bus.surv_valid && n < 40) begin
      if (bus.acs_input_sig) begin
        chk("issue_slot", n, issued + 1);
        chk("issue_state", bus.acs_self_state, issued);
        chk("issue_addr1", bus.acs_addr_in_1, (issued % 2) * 2);
        chk("issue_addr2", bus.acs_addr_in_2, (issued % 2) * 2 + 1);
        chk("issue_sym", bus.acs_data_recv, sym);
        chk("issue_pmin1", bus.acs_pmin1, m_pm[(issued % 2) * 2]);
        chk("issue_pmin2", bus.acs_pmin2, m_pm[(issued % 2) * 2 + 1]);
        issued++;
      end else begin
        chk("acs_quiet", {bus.acs_self_state, bus.acs_data_recv, bus.acs_addr_in_1,
                          bus.acs_addr_in_2, bus.acs_pmin1, bus.acs_pmin2}, 0);
      end
      chk("busy_not_ready", bus.sym_ready, 0);
      norm_cnt += int'(bus.norm_evt);
      @(negedge clk);
      n++;
    end
    bus.sym_valid   = 1'b0;
    bus.frame_start = 1'b0;
    chk("out_latency", n, 6 + LAT);
    chk("issue_count", issued, 4);
    chk("norm_pulses", norm_cnt, xn);
    chk("out_surv", bus.surv_data, xs);
    chk("out_best", bus.best_state, xb);
    chk("out_not_ready", bus.sym_ready, 0);
    repeat (hold) begin
      @(negedge clk);
      chk("stall_hold", {bus.surv_valid, bus.sym_ready, bus.surv_data, bus.best_state},
          {1'b1, 1'b0, xs, xb});
    end
    bus.surv_ready = 1'b1;
    @(negedge clk);
    chk("release_idle", {bus.sym_ready, bus.surv_valid}, 2'b10);
    chk("result_held", {bus.surv_data, bus.best_state}, {xs, xb});
  endtask

  task automatic do_sym(input logic [1:0] sym, input logic fs, input int mode, input int hold);
    if (fs) model_init();
    acs_mode = mode;
    ref_step(sym, mode);
    run_symbol(sym, fs, e_surv, e_best, e_norm, hold);
    for (int s = 0; s < 4; s++) m_pm[s] = m_nx[s];
  endtask

  typedef struct {
    logic [3:0][PM_W-1:0] fpm;
    logic [3:0]           fdec;
    logic [3:0][PM_W-1:0] epm;
    logic [3:0]           esurv;
    logic [1:0]           ebest;
    logic                 enorm;
    int                   hold;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int n;
    // packed arrays listed {state3, state2, state1, state0}
    tbl[0] = '{fpm: {7'd127, 7'd80, 7'd72, 7'd70}, fdec: 4'b1010,
               epm: {7'd63, 7'd16, 7'd8, 7'd6}, esurv: 4'b1010, ebest: 2'd0, enorm: 1'b1, hold: 0};
    tbl[1] = '{fpm: {7'd9, 7'd3, 7'd3, 7'd5}, fdec: 4'b0110,
               epm: {7'd9, 7'd3, 7'd3, 7'd5}, esurv: 4'b0110, ebest: 2'd1, enorm: 1'b0, hold: 20};
    tbl[2] = '{fpm: {7'd64, 7'd64, 7'd64, 7'd64}, fdec: 4'b1111,
               epm: {7'd0, 7'd0, 7'd0, 7'd0}, esurv: 4'b1111, ebest: 2'd0, enorm: 1'b1, hold: 0};
    tbl[3] = '{fpm: {7'd127, 7'd127, 7'd63, 7'd127}, fdec: 4'b0001,
               epm: {7'd127, 7'd127, 7'd63, 7'd127}, esurv: 4'b0001, ebest: 2'd1, enorm: 1'b0, hold: 3};
    tbl[4] = '{fpm: {7'd80, 7'd90, 7'd90, 7'd100}, fdec: 4'b1100,
               epm: {7'd16, 7'd26, 7'd26, 7'd36}, esurv: 4'b1100, ebest: 2'd3, enorm: 1'b1, hold: 0};
    tbl[5] = '{fpm: {7'd9, 7'd9, 7'd9, 7'd9}, fdec: 4'b0101,
               epm: {7'd9, 7'd9, 7'd9, 7'd9}, esurv: 4'b0101, ebest: 2'd0, enorm: 1'b0, hold: 0};

    bus.sym_valid   = 1'b0;
    bus.sym_data    = '0;
    bus.frame_start = 1'b0;
    bus.surv_ready  = 1'b1;
    #1;
    chk("reset_ready", bus.sym_ready, 1);
    chk("reset_outs", {bus.acs_input_sig, bus.surv_valid, bus.surv_data,
                       bus.best_state, bus.norm_evt, bus.acs_pmin1, bus.acs_pmin2}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_init();

    // Frame start with plain-min ACS, then a continuation symbol
    do_sym(2'b00, 1'b1, 0, 0);
    do_sym(2'b10, 1'b0, 0, 0);

    // Forced-metric vectors: normalisation, ties, stall
    for (int i = 0; i < 6; i++) begin
      acs_mode  = 2;
      force_pm  = tbl[i].fpm;
      force_dec = tbl[i].fdec;
      run_symbol(2'($urandom_range(0, 3)), 1'b0, tbl[i].esurv, tbl[i].ebest,
                 tbl[i].enorm, tbl[i].hold);
      for (int s = 0; s < 4; s++) m_pm[s] = int'(tbl[i].epm[s]);
    end

    // Async reset while state 2 is being issued
    acs_mode = 1;
    bus.sym_valid = 1'b1;
    bus.sym_data  = 2'b11;
    @(posedge clk);
    @(negedge clk);
    bus.sym_valid = 1'b0;
    n = 0;
    while (!(bus.acs_input_sig && bus.acs_self_state == 2'd2) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idx2", n, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", bus.sym_ready, 1);
    chk("async_rst_acs", {bus.acs_input_sig, bus.acs_self_state, bus.acs_data_recv,
                          bus.acs_addr_in_1, bus.acs_addr_in_2, bus.acs_pmin1, bus.acs_pmin2}, 0);
    chk("async_rst_surv", {bus.surv_valid, bus.surv_data, bus.best_state, bus.norm_evt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_init();
    do_sym(2'b01, 1'b0, 0, 0);

    // Randomized symbols against the trellis model
    for (int i = 0; i < 40; i++) begin
      logic fs;
      fs = (i != 0) && ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 4) == 0) begin
        bus.frame_start = 1'b1;
        repeat (2) @(negedge clk);
        bus.frame_start = 1'b0;
      end
      do_sym(2'($urandom_range(0, 3)), fs, 1, ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
